// File: rtl/shader_pkg.sv
// Shared types and fixed-point helpers for the ray/voxel shader array.
// Ray parameters are Q(COORD_W).(FRAC_W); t values carry two guard bits.
package shader_pkg;

   localparam int COORD_W = 8;
   localparam int FRAC_W  = 8;
   localparam int T_W     = COORD_W + FRAC_W + 2;
   localparam int PROD_W  = T_W + COORD_W + FRAC_W;

   localparam logic signed [T_W-1:0] T_MAX = {1'b0, {(T_W-1){1'b1}}};
   localparam logic signed [T_W-1:0] T_MIN = {1'b1, {(T_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RASTER,
      DRAIN,
      DONE_RASTERIZING,
      SHADE,
      DONE_SHADING
   } shader_state_t;

   // Rescale a d*inv product back to Q.F and clamp it into the t range.
   function automatic logic signed [T_W-1:0] sat_t(input logic signed [PROD_W-1:0] prod);
      logic signed [PROD_W-1:0] shifted;
      shifted = prod >>> FRAC_W;
      if ((&shifted[PROD_W-1:T_W-1]) || !(|shifted[PROD_W-1:T_W-1]))
         return shifted[T_W-1:0];
      else if (shifted[PROD_W-1])
         return T_MIN;
      else
         return T_MAX;
   endfunction

   function automatic logic signed [T_W-1:0] t_min2(input logic signed [T_W-1:0] a,
                                                     input logic signed [T_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic signed [T_W-1:0] t_max2(input logic signed [T_W-1:0] a,
                                                     input logic signed [T_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slab_axis.sv
// One axis of the ray/AABB slab test: entry/exit distances for a voxel
// slab, three register stages deep.
module slab_axis
   import shader_pkg::*;
#(
   parameter int COORD_BITS = COORD_W,
   parameter int FRAC_BITS  = FRAC_W
) (
   input  logic                                  clock,
   input  logic [COORD_BITS-1:0]                 voxel_coord,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] ray_inv,
   input  logic                                  ray_zero,
   output logic signed [T_W-1:0]                 lo_p3,
   output logic signed [T_W-1:0]                 hi_p3,
   output logic                                  miss_p3
);

   logic [COORD_BITS:0]      coord_next;
   logic signed [T_W-1:0]    corner_a;
   logic signed [T_W-1:0]    corner_b;
   logic signed [T_W-1:0]    pos_ext;
   logic signed [T_W-1:0]    da_p1;
   logic signed [T_W-1:0]    db_p1;
   logic                     zero_p1;
   logic signed [PROD_W-1:0] prod_a;
   logic signed [PROD_W-1:0] prod_b;
   logic                     inside_s2;
   logic signed [T_W-1:0]    ta_p2;
   logic signed [T_W-1:0]    tb_p2;
   logic                     zero_p2;
   logic                     inside_p2;

   assign coord_next = {1'b0, voxel_coord} + (COORD_BITS+1)'(1);
   assign corner_a   = signed'({2'b00, voxel_coord, {FRAC_BITS{1'b0}}});
   assign corner_b   = signed'({1'b0, coord_next, {FRAC_BITS{1'b0}}});
   assign pos_ext    = T_W'(cam_pos);

   assign prod_a = PROD_W'(da_p1) * PROD_W'(ray_inv);
   assign prod_b = PROD_W'(db_p1) * PROD_W'(ray_inv);

   // Origin lies inside the slab when corner_a <= pos < corner_b.
   assign inside_s2 = (da_p1[T_W-1] || (da_p1 == '0)) && !db_p1[T_W-1] && (db_p1 != '0);

   always_ff @(posedge clock) begin
      // S1: offsets of both slab planes from the ray origin
      da_p1   <= corner_a - pos_ext;
      db_p1   <= corner_b - pos_ext;
      zero_p1 <= ray_zero;
      // S2: plane distances along the ray
      ta_p2     <= sat_t(prod_a);
      tb_p2     <= sat_t(prod_b);
      zero_p2   <= zero_p1;
      inside_p2 <= inside_s2;
      // S3: ordered entry/exit for this axis
      lo_p3   <= zero_p2 ? T_MIN : t_min2(ta_p2, tb_p2);
      hi_p3   <= zero_p2 ? T_MAX : t_max2(ta_p2, tb_p2);
      miss_p3 <= zero_p2 && !inside_p2;
   end

endmodule

// File: rtl/ray_voxel_shader.sv
// Per-pixel ray/voxel shader: streams voxels through a pipelined slab test,
// keeps the nearest hit, and drives its palette id when selected in the shade pass.
module ray_voxel_shader
   import shader_pkg::*;
#(
   parameter int ROW          = 0,
   parameter int COL          = 0,
   parameter int ROW_BITS     = 8,
   parameter int COL_BITS     = 8,
   parameter int COORD_BITS   = COORD_W,
   parameter int FRAC_BITS    = FRAC_W,
   parameter int PALETTE_BITS = 8,
   parameter int PIXEL_BITS   = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            do_rasterize,
   input  logic                            do_shade,
   input  logic                            voxel_valid,
   output logic                            voxel_ready,
   input  logic                            voxel_last,
   input  logic [COORD_BITS-1:0]           voxel_x,
   input  logic [COORD_BITS-1:0]           voxel_y,
   input  logic [COORD_BITS-1:0]           voxel_z,
   input  logic [PALETTE_BITS-1:0]         voxel_id,
   input  logic [COORD_BITS+FRAC_BITS-1:0] cam_pos_x,
   input  logic [COORD_BITS+FRAC_BITS-1:0] cam_pos_y,
   input  logic [COORD_BITS+FRAC_BITS-1:0] cam_pos_z,
   input  logic [COORD_BITS+FRAC_BITS-1:0] ray_inv_x,
   input  logic [COORD_BITS+FRAC_BITS-1:0] ray_inv_y,
   input  logic [COORD_BITS+FRAC_BITS-1:0] ray_inv_z,
   input  logic                            ray_zero_x,
   input  logic                            ray_zero_y,
   input  logic                            ray_zero_z,
   input  logic [ROW_BITS-1:0]             row,
   input  logic [COL_BITS-1:0]             col,
   output logic                            rasterizing_done,
   output logic                            shading_done,
   output logic                            pixel_oe,
   output logic [PIXEL_BITS-1:0]           pixel
);

   shader_state_t             state;
   shader_state_t             state_next;
   logic                      accept;
   logic                      pipe_busy;
   logic                      selected;
   logic                      vld_p1, vld_p2, vld_p3, vld_p4;
   logic [PALETTE_BITS-1:0]   id_p1, id_p2, id_p3, id_p4;
   logic signed [T_W-1:0]     lo_x_p3, lo_y_p3, lo_z_p3;
   logic signed [T_W-1:0]     hi_x_p3, hi_y_p3, hi_z_p3;
   logic                      miss_x_p3, miss_y_p3, miss_z_p3;
   logic signed [T_W-1:0]     tnear_s3;
   logic signed [T_W-1:0]     tfar_s3;
   logic signed [T_W-1:0]     tnear_p4;
   logic signed [T_W-1:0]     tfar_p4;
   logic                      miss_p4;
   logic signed [T_W-1:0]     tn_s4;
   logic                      hit_s4;
   logic signed [T_W-1:0]     depth;
   logic [PALETTE_BITS-1:0]   hit_id;

   assign accept    = voxel_valid && voxel_ready;
   assign pipe_busy = vld_p1 || vld_p2 || vld_p3 || vld_p4;
   assign selected  = (row == ROW_BITS'(ROW)) && (col == COL_BITS'(COL));

   slab_axis #(.COORD_BITS(COORD_BITS), .FRAC_BITS(FRAC_BITS)) u_slab_x (
      .clock       (clock),
      .voxel_coord (voxel_x),
      .cam_pos     (signed'(cam_pos_x)),
      .ray_inv     (signed'(ray_inv_x)),
      .ray_zero    (ray_zero_x),
      .lo_p3       (lo_x_p3),
      .hi_p3       (hi_x_p3),
      .miss_p3     (miss_x_p3)
   );

   slab_axis #(.COORD_BITS(COORD_BITS), .FRAC_BITS(FRAC_BITS)) u_slab_y (
      .clock       (clock),
      .voxel_coord (voxel_y),
      .cam_pos     (signed'(cam_pos_y)),
      .ray_inv     (signed'(ray_inv_y)),
      .ray_zero    (ray_zero_y),
      .lo_p3       (lo_y_p3),
      .hi_p3       (hi_y_p3),
      .miss_p3     (miss_y_p3)
   );

   slab_axis #(.COORD_BITS(COORD_BITS), .FRAC_BITS(FRAC_BITS)) u_slab_z (
      .clock       (clock),
      .voxel_coord (voxel_z),
      .cam_pos     (signed'(cam_pos_z)),
      .ray_inv     (signed'(ray_inv_z)),
      .ray_zero    (ray_zero_z),
      .lo_p3       (lo_z_p3),
      .hi_p3       (hi_z_p3),
      .miss_p3     (miss_z_p3)
   );

   // S3: combine the three axis intervals
   assign tnear_s3 = t_max2(t_max2(lo_x_p3, lo_y_p3), lo_z_p3);
   assign tfar_s3  = t_min2(t_min2(hi_x_p3, hi_y_p3), hi_z_p3);

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         vld_p4 <= 1'b0;
      end else begin
         vld_p1 <= accept;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         vld_p4 <= vld_p3;
      end
   end

   always_ff @(posedge clock) begin
      id_p1    <= voxel_id;
      id_p2    <= id_p1;
      id_p3    <= id_p2;
      id_p4    <= id_p3;
      tnear_p4 <= tnear_s3;
      tfar_p4  <= tfar_s3;
      miss_p4  <= miss_x_p3 || miss_y_p3 || miss_z_p3;
   end

   // S4: strict less-than so an equal-depth later voxel never replaces an earlier one
   assign tn_s4  = tnear_p4[T_W-1] ? '0 : tnear_p4;
   assign hit_s4 = vld_p4 && (id_p4 != '0) && !miss_p4 && (tnear_p4 <= tfar_p4) &&
                   !tfar_p4[T_W-1] && (tn_s4 < depth);

   always_ff @(posedge clock) begin
      if (reset) begin
         depth    <= T_MAX;
         hit_id   <= '0;
         pixel    <= '0;
         pixel_oe <= 1'b0;
      end else begin
         if (state == CLEAR) begin
            depth    <= T_MAX;
            hit_id   <= '0;
            pixel    <= '0;
            pixel_oe <= 1'b0;
         end else if (hit_s4) begin
            depth  <= tn_s4;
            hit_id <= id_p4;
         end
         if (state == SHADE) begin
            pixel    <= selected ? PIXEL_BITS'(hit_id) : '0;
            pixel_oe <= selected;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next       = state;
      voxel_ready      = 1'b0;
      rasterizing_done = 1'b0;
      shading_done     = 1'b0;
      case (state)
         IDLE: begin
            if (do_rasterize)  state_next = CLEAR;
            else if (do_shade) state_next = SHADE;
         end
         CLEAR:  state_next = RASTER;
         RASTER: begin
            voxel_ready = 1'b1;
            if (voxel_valid && voxel_last) state_next = DRAIN;
         end
         DRAIN: begin
            if (!pipe_busy) state_next = DONE_RASTERIZING;
         end
         DONE_RASTERIZING: begin
            rasterizing_done = 1'b1;
            if (!do_rasterize) state_next = IDLE;
         end
         SHADE: state_next = DONE_SHADING;
         DONE_SHADING: begin
            shading_done = 1'b1;
            if (!do_shade) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ray_voxel_shader.sv
// Directed bench for ray_voxel_shader: expected frame results and shade outputs
// are queued at issue time and checked by a monitor when the DUT reports done.
module tb_ray_voxel_shader;
   import shader_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        do_rasterize, do_shade;
   logic        voxel_valid, voxel_ready, voxel_last;
   logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
   logic [15:0] cam_pos_x, cam_pos_y, cam_pos_z;
   logic [15:0] ray_inv_x, ray_inv_y, ray_inv_z;
   logic        ray_zero_x, ray_zero_y, ray_zero_z;
   logic [7:0]  row, col;
   logic        rasterizing_done, shading_done, pixel_oe;
   logic [7:0]  pixel;

   always #5 clock = ~clock;

   ray_voxel_shader #(
      .ROW(0), .COL(0), .ROW_BITS(8), .COL_BITS(8), .COORD_BITS(8), .FRAC_BITS(8),
      .PALETTE_BITS(8), .PIXEL_BITS(8)
   ) dut (
      .clock(clock), .reset(reset), .do_rasterize(do_rasterize), .do_shade(do_shade),
      .voxel_valid(voxel_valid), .voxel_ready(voxel_ready), .voxel_last(voxel_last),
      .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
      .cam_pos_x(cam_pos_x), .cam_pos_y(cam_pos_y), .cam_pos_z(cam_pos_z),
      .ray_inv_x(ray_inv_x), .ray_inv_y(ray_inv_y), .ray_inv_z(ray_inv_z),
      .ray_zero_x(ray_zero_x), .ray_zero_y(ray_zero_y), .ray_zero_z(ray_zero_z),
      .row(row), .col(col), .rasterizing_done(rasterizing_done), .shading_done(shading_done),
      .pixel_oe(pixel_oe), .pixel(pixel)
   );

   localparam logic [31:0] EXP_TMAX = 32'h0001_FFFF;

   typedef struct { logic [31:0] depth; logic [31:0] id; } rexp_t;
   typedef struct { logic [31:0] oe; logic [31:0] pix; } sexp_t;
   rexp_t rq[$];
   sexp_t sq[$];
   rexp_t r_exp;
   sexp_t s_exp;

   int n_cmp = 0;
   int n_bad = 0;
   int accepted = 0;
   int acc0;
   logic rd_q = 1'b0;
   logic sd_q = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (voxel_valid && voxel_ready && !reset) accepted <= accepted + 1;
   end

   // Monitor: compare against the queued expectation whenever a pass completes.
   always @(negedge clock) begin
      if (rasterizing_done && !rd_q) begin
         if (rq.size() == 0) check("raster_unexpected", 32'd1, 32'd0);
         else begin
            r_exp = rq.pop_front();
            check("frame_depth", 32'(dut.depth), r_exp.depth);
            check("frame_hit_id", 32'(dut.hit_id), r_exp.id);
         end
      end
      if (shading_done && !sd_q) begin
         if (sq.size() == 0) check("shade_unexpected", 32'd1, 32'd0);
         else begin
            s_exp = sq.pop_front();
            check("shade_pixel_oe", 32'(pixel_oe), s_exp.oe);
            check("shade_pixel", 32'(pixel), s_exp.pix);
         end
      end
      rd_q <= rasterizing_done;
      sd_q <= shading_done;
   end

   task automatic start_raster();
      logic ok;
      ok = 1'b0;
      do_rasterize = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         tick();
         ok = voxel_ready;
      end
      check("raster_start_ready", 32'(ok), 32'd1);
   endtask

   task automatic send_voxel(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                             input logic [7:0] id, input logic last, input logic keep);
      logic ok;
      ok = 1'b0;
      voxel_x = x; voxel_y = y; voxel_z = z; voxel_id = id;
      voxel_last  = last;
      voxel_valid = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         ok = voxel_ready;
         tick();
      end
      check("voxel_accept", 32'(ok), 32'd1);
      voxel_last = 1'b0;
      if (!keep) voxel_valid = 1'b0;
   endtask

   task automatic end_raster(input logic [31:0] exp_depth, input logic [31:0] exp_id);
      logic ok;
      rq.push_back('{exp_depth, exp_id});
      ok = rasterizing_done;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         ok = rasterizing_done;
      end
      check("raster_done_seen", 32'(ok), 32'd1);
      do_rasterize = 1'b0;
      tick();
   endtask

   task automatic shade(input logic [7:0] r, input logic [7:0] c,
                        input logic [31:0] exp_oe, input logic [31:0] exp_pix);
      logic ok;
      sq.push_back('{exp_oe, exp_pix});
      row = r; col = c;
      do_shade = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         tick();
         ok = shading_done;
      end
      check("shade_done_seen", 32'(ok), 32'd1);
      tick();
      tick();
      check("shade_done_hold", 32'(shading_done), 32'd1);
      do_shade = 1'b0;
      tick();
      check("shade_done_release", 32'(shading_done), 32'd0);
      check("pixel_held", 32'(pixel), exp_pix);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; do_rasterize = 1'b0; do_shade = 1'b0;
      voxel_valid = 1'b0; voxel_last = 1'b0;
      voxel_x = '0; voxel_y = '0; voxel_z = '0; voxel_id = '0;
      cam_pos_x = 16'h0000; cam_pos_y = 16'h0080; cam_pos_z = 16'h0080;
      ray_inv_x = 16'h0100; ray_inv_y = 16'h0000; ray_inv_z = 16'h0000;
      ray_zero_x = 1'b0; ray_zero_y = 1'b1; ray_zero_z = 1'b1;
      row = '0; col = '0;
      repeat (3) tick();
      check("rst_voxel_ready", 32'(voxel_ready), 32'd0);
      check("rst_raster_done", 32'(rasterizing_done), 32'd0);
      check("rst_shade_done", 32'(shading_done), 32'd0);
      check("rst_pixel_oe", 32'(pixel_oe), 32'd0);
      check("rst_pixel", 32'(pixel), 32'd0);
      check("rst_hit_id", 32'(dut.hit_id), 32'd0);
      check("rst_depth", 32'(dut.depth), EXP_TMAX);
      reset = 1'b0;
      tick();

      // Frame 1: single hit at t=4.0, with latency probe.
      start_raster();
      send_voxel(8'd4, 8'd0, 8'd0, 8'd7, 1'b1, 1'b0);
      repeat (3) tick();
      check("latency_early_hit_id", 32'(dut.hit_id), 32'd0);
      tick();
      check("latency_hit_id", 32'(dut.hit_id), 32'd7);
      check("latency_depth", 32'(dut.depth), 32'h0400);
      end_raster(32'h0400, 32'd7);
      shade(8'd0, 8'd0, 32'd1, 32'd7);
      shade(8'd1, 8'd0, 32'd0, 32'd0);

      // Frame 2: nearer, farther and equal-depth voxels back to back, valid held high.
      start_raster();
      acc0 = accepted;
      send_voxel(8'd2, 8'd0, 8'd0, 8'd9, 1'b0, 1'b1);
      do_rasterize = 1'b0;
      send_voxel(8'd6, 8'd0, 8'd0, 8'd3, 1'b0, 1'b1);
      send_voxel(8'd2, 8'd0, 8'd0, 8'd5, 1'b1, 1'b1);
      check("drain_ready_low", 32'(voxel_ready), 32'd0);
      end_raster(32'h0200, 32'd9);
      repeat (2) tick();
      check("accepted_beats", 32'(accepted - acc0), 32'd3);
      voxel_valid = 1'b0;
      shade(8'd0, 8'd0, 32'd1, 32'd9);

      // Frame 3: voxel behind the origin.
      cam_pos_x = 16'h0A00;
      start_raster();
      send_voxel(8'd2, 8'd0, 8'd0, 8'd4, 1'b1, 1'b0);
      end_raster(EXP_TMAX, 32'd0);
      shade(8'd0, 8'd0, 32'd1, 32'd0);

      // Frame 4: empty palette id, then a voxel outside the y slab.
      cam_pos_x = 16'h0000;
      start_raster();
      send_voxel(8'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      send_voxel(8'd4, 8'd1, 8'd0, 8'd6, 1'b1, 1'b0);
      end_raster(EXP_TMAX, 32'd0);
      shade(8'd0, 8'd0, 32'd1, 32'd0);

      // Frame 5: reset while a voxel is in flight.
      start_raster();
      send_voxel(8'd3, 8'd0, 8'd0, 8'd8, 1'b0, 1'b0);
      reset = 1'b1;
      do_rasterize = 1'b0;
      tick();
      check("abort_voxel_ready", 32'(voxel_ready), 32'd0);
      check("abort_hit_id", 32'(dut.hit_id), 32'd0);
      check("abort_depth", 32'(dut.depth), EXP_TMAX);
      reset = 1'b0;
      repeat (6) tick();
      check("abort_flushed_hit_id", 32'(dut.hit_id), 32'd0);
      check("abort_raster_done", 32'(rasterizing_done), 32'd0);

      check("raster_queue_empty", 32'(rq.size()), 32'd0);
      check("shade_queue_empty", 32'(sq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
